// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters; result returns 2 edges after the grant cycle.
// One operation in flight; DONE holds result and ALU inputs until the owning requester asserts its resp ready.
module alu_arbiter #(
    parameter int              WIDTH   = 16,
    parameter int              OPW     = 3,
    parameter logic [OPW-1:0]  ALU_ADD = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic [OPW-1:0]   req1_op,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_z,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_z,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               prio_q, prio_d;
    logic               owner_q, owner_d;
    logic [WIDTH-1:0]   alu_x_q, alu_x_d;
    logic [WIDTH-1:0]   alu_y_q, alu_y_d;
    logic [OPW-1:0]     alu_op_q, alu_op_d;
    logic [WIDTH-1:0]   resp_z_q, resp_z_d;
    logic               resp0_valid_q, resp0_valid_d;
    logic               resp1_valid_q, resp1_valid_d;
    logic               busy_q, busy_d;
    logic               grant0, grant1;
    logic               owner_rdy;

    // prio_q names the port that wins when both request
    always_comb begin
        grant0     = req0_valid & (~req1_valid | ~prio_q);
        grant1     = req1_valid & ~grant0;
        req0_ready = (state_q == IDLE) & grant0;
        req1_ready = (state_q == IDLE) & grant1;
        owner_rdy  = owner_q ? resp1_ready : resp0_ready;
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        alu_x_d  = alu_x_q;
        alu_y_d  = alu_y_q;
        alu_op_d = alu_op_q;
        resp_z_d = resp_z_q;
        case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    alu_x_d  = req0_x;
                    alu_y_d  = req0_y;
                    alu_op_d = req0_op;
                    owner_d  = 1'b0;
                    prio_d   = 1'b1;
                    state_d  = EXEC;
                end else if (req1_ready) begin
                    alu_x_d  = req1_x;
                    alu_y_d  = req1_y;
                    alu_op_d = req1_op;
                    owner_d  = 1'b1;
                    prio_d   = 1'b0;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                resp_z_d = alu_z;
                state_d  = DONE;
            end
            DONE: begin
                if (owner_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Response valids and busy are registered from the next-state decode
        resp0_valid_d = (state_d == DONE) & ~owner_d;
        resp1_valid_d = (state_d == DONE) &  owner_d;
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            prio_q        <= 1'b0;
            owner_q       <= 1'b0;
            alu_x_q       <= '0;
            alu_y_q       <= '0;
            alu_op_q      <= ALU_ADD;
            resp_z_q      <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            prio_q        <= prio_d;
            owner_q       <= owner_d;
            alu_x_q       <= alu_x_d;
            alu_y_q       <= alu_y_d;
            alu_op_q      <= alu_op_d;
            resp_z_q      <= resp_z_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign resp_z      = resp_z_q;
    assign alu_x       = alu_x_q;
    assign alu_y       = alu_y_q;
    assign alu_op      = alu_op_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: reference ALU drives alu_z, scoreboard checks each returned result and its port.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_x, req0_y, req1_x, req1_y;
    logic [2:0]  req0_op, req1_op;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [15:0] resp_z, alu_x, alu_y, alu_z;
    logic [2:0]  alu_op;
    logic        busy;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(16), .OPW(3), .ALU_ADD(3'd0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_z(resp_z), .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_z(alu_z), .busy(busy)
    );

    function automatic logic [15:0] alu_ref(input logic [15:0] x, input logic [15:0] y,
                                            input logic [2:0] op);
        case (op)
            3'd0:    alu_ref = x + y;
            3'd1:    alu_ref = x - y;
            3'd2:    alu_ref = x & y;
            3'd3:    alu_ref = x | y;
            3'd4:    alu_ref = x ^ y;
            3'd5:    alu_ref = ~x;
            3'd6:    alu_ref = x << 1;
            default: alu_ref = x >> 1;
        endcase
    endfunction

    assign alu_z = alu_ref(alu_x, alu_y, alu_op);

    typedef struct {
        logic        port;
        logic [15:0] z;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic got_resp(input logic port);
        exp_t e;
        if (sb.size() == 0) begin
            chk_eq("resp_spurious", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk_eq("resp_port", {31'b0, port}, {31'b0, e.port});
            chk_eq("resp_z", resp_z, e.z);
        end
    endtask

    // Push on accept, pop on response handshake; inputs change only just after posedge
    always @(negedge clk) begin
        if (!reset) begin
            if (req0_valid && req0_ready)
                sb.push_back('{1'b0, alu_ref(req0_x, req0_y, req0_op)});
            else if (req1_valid && req1_ready)
                sb.push_back('{1'b1, alu_ref(req1_x, req1_y, req1_op)});
            if (resp0_valid && resp0_ready) got_resp(1'b0);
            if (resp1_valid && resp1_ready) got_resp(1'b1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        #2;
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        chk_eq("drain", sb.size(), 0);
    endtask

    task automatic wait_grant();
        for (int k = 0; k < 10 && !(req0_ready || req1_ready); k++) step();
        chk_eq("grant_timeout", {31'b0, req0_ready | req1_ready}, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] hz, hx, hy;
    logic [2:0]  hop;
    logic        p;

    initial begin
        reset = 1'b0;
        req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
        req0_x = 0; req0_y = 0; req0_op = 0;
        req1_x = 0; req1_y = 0; req1_op = 0;

        // Reset asserted mid-cycle takes effect without a clock edge
        #2 reset = 1'b1;
        #1;
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_alu_op", alu_op, 3'd0);
        chk_eq("rst_alu_x", alu_x, 0);
        chk_eq("rst_alu_y", alu_y, 0);
        chk_eq("rst_resp_z", resp_z, 0);
        chk_eq("rst_resp0_valid", resp0_valid, 0);
        chk_eq("rst_resp1_valid", resp1_valid, 0);
        step(); step();
        reset = 1'b0;
        step();

        // Single op on port 0
        req0_valid = 1; req0_x = 16'h0001; req0_y = 16'hffff; req0_op = 3'd0;
        resp0_ready = 1; resp1_ready = 1;
        #1;
        chk_eq("single_req0_ready", req0_ready, 1);
        chk_eq("single_req1_ready", req1_ready, 0);
        step();
        req0_valid = 0;
        chk_eq("single_exec_busy", busy, 1);
        chk_eq("single_exec_alu_x", alu_x, 16'h0001);
        chk_eq("single_exec_alu_y", alu_y, 16'hffff);
        chk_eq("single_exec_resp0", resp0_valid, 0);
        step();
        chk_eq("single_done_resp0", resp0_valid, 1);
        chk_eq("single_done_resp1", resp1_valid, 0);
        chk_eq("single_done_z", resp_z, 16'h0000);
        step();
        chk_eq("single_idle_resp0", resp0_valid, 0);
        chk_eq("single_idle_busy", busy, 0);
        drain();

        // Contention: both valid continuously from reset, expect 0,1,0,1
        do_reset();
        req0_valid = 1; req0_x = 16'($urandom); req0_y = 16'($urandom); req0_op = 3'($urandom_range(0, 7));
        req1_valid = 1; req1_x = 16'($urandom); req1_y = 16'($urandom); req1_op = 3'($urandom_range(0, 7));
        for (int i = 0; i < 4; i++) begin
            #1;
            wait_grant();
            chk_eq("rr_both_ready", {31'b0, req0_ready & req1_ready}, 0);
            chk_eq("rr_order", {31'b0, req1_ready}, i % 2);
            p = req1_ready;
            step();
            if (p) begin
                req1_x = 16'($urandom); req1_y = 16'($urandom); req1_op = 3'($urandom_range(0, 7));
            end else begin
                req0_x = 16'($urandom); req0_y = 16'($urandom); req0_op = 3'($urandom_range(0, 7));
            end
        end
        req0_valid = 0; req1_valid = 0;
        drain();
        step();

        // Response backpressure on port 1, req0 and resp0_ready ignored meanwhile
        resp1_ready = 0; resp0_ready = 0;
        req1_valid = 1; req1_x = 16'habcd; req1_y = 16'h1234; req1_op = 3'd4;
        #1;
        chk_eq("bp_req1_ready", req1_ready, 1);
        step();
        req1_valid = 0;
        req0_valid = 1; req0_x = 16'h0007; req0_y = 16'h0009; req0_op = 3'd1;
        #1;
        chk_eq("bp_exec_req0_ready", req0_ready, 0);
        step();
        chk_eq("bp_done_resp1", resp1_valid, 1);
        hz = resp_z; hx = alu_x; hy = alu_y; hop = alu_op;
        for (int i = 0; i < 5; i++) begin
            resp0_ready = 1'(i % 2);
            step();
            chk_eq("bp_hold_resp1", resp1_valid, 1);
            chk_eq("bp_hold_resp0", resp0_valid, 0);
            chk_eq("bp_hold_z", resp_z, hz);
            chk_eq("bp_hold_alu_x", alu_x, hx);
            chk_eq("bp_hold_alu_y", alu_y, hy);
            chk_eq("bp_hold_alu_op", alu_op, hop);
            chk_eq("bp_hold_req0_ready", req0_ready, 0);
        end
        resp0_ready = 1; resp1_ready = 1;
        #1;
        chk_eq("bp_release_req0_ready", req0_ready, 0);
        step();
        chk_eq("bp_idle_resp1", resp1_valid, 0);
        chk_eq("bp_idle_req0_ready", req0_ready, 1);
        step();
        req0_valid = 0;
        chk_eq("bp_req0_accepted", busy, 1);
        drain();
        step();

        // Reset during EXEC discards the operation
        req0_valid = 1; req0_x = 16'h1234; req0_y = 16'h0001; req0_op = 3'd0;
        #1;
        chk_eq("mr_req0_ready", req0_ready, 1);
        step();
        req0_valid = 0;
        chk_eq("mr_exec_busy", busy, 1);
        reset = 1'b1;
        sb.delete();
        #1;
        chk_eq("mr_rst_busy", busy, 0);
        chk_eq("mr_rst_alu_x", alu_x, 0);
        chk_eq("mr_rst_resp0", resp0_valid, 0);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_eq("mr_no_resp0", resp0_valid, 0);
        end
        req0_valid = 1; req1_valid = 1;
        req1_x = 16'h00f0; req1_y = 16'h0f00; req1_op = 3'd3;
        #1;
        chk_eq("mr_prio_req0", req0_ready, 1);
        chk_eq("mr_prio_req1", req1_ready, 0);
        step();
        req0_valid = 0; req1_valid = 0;
        drain();

        chk_eq("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
